// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared sizing, types and constants for the architectural register file.
//   Exports:
//     DATA_W     bits per register
//     REG_COUNT  number of architectural registers
//     ADDR_W     register address width, log2(REG_COUNT)
//     reg_addr_t register index type
//     reg_data_t register value type
//     ZERO_REG   index of the hardwired-zero register
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage : regfile_pkg

// File: rtl/regfile_wdec.sv
// ----------------------------------------------------------------------------
// regfile_wdec
//   Address-to-one-hot decoder with enable. Only registers 1..REG_COUNT-1
//   have a select line: register 0 has no storage and no scoreboard bit, so
//   it is never selected.
//
//   Ports:
//     en    input   1                   decode enable
//     addr  input   ADDR_W              register index to select
//     sel   output  [REG_COUNT-1:1]     one-hot select, all zero when en=0
//                                       or addr selects register 0
// ----------------------------------------------------------------------------
module regfile_wdec
    import regfile_pkg::*;
#(
    parameter int ADDR_W    = regfile_pkg::ADDR_W,
    parameter int REG_COUNT = regfile_pkg::REG_COUNT
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [REG_COUNT-1:1] sel
);

    always_comb begin
        sel = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            sel[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule : regfile_wdec

// File: rtl/register_file_rw.sv
// ----------------------------------------------------------------------------
// register_file_rw
//   32 x 32-bit architectural register file with one write port, two
//   combinational read ports and a per-register busy scoreboard. Register 0
//   is hardwired to zero. Reads see a write presented in the same cycle.
//
//   Ports:
//     clk        input   1       rising-edge clock
//     reset      input   1       synchronous active-high reset; clears all
//                                registers and busy bits
//     wr_en      input   1       write-back valid
//     wr_addr    input   ADDR_W  write destination
//     wr_data    input   DATA_W  write value
//     rd_addr_a  input   ADDR_W  read port A address
//     rd_data_a  output  DATA_W  read port A data (combinational)
//     rd_addr_b  input   ADDR_W  read port B address
//     rd_data_b  output  DATA_W  read port B data (combinational)
//     rsv_en     input   1       issue reserves a destination register
//     rsv_addr   input   ADDR_W  register being reserved
//     busy_a     output  1       register at rd_addr_a has a pending producer
//     busy_b     output  1       register at rd_addr_b has a pending producer
// ----------------------------------------------------------------------------
module register_file_rw
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      wr_en,
    input  reg_addr_t wr_addr,
    input  reg_data_t wr_data,
    input  reg_addr_t rd_addr_a,
    output reg_data_t rd_data_a,
    input  reg_addr_t rd_addr_b,
    output reg_data_t rd_data_b,
    input  logic      rsv_en,
    input  reg_addr_t rsv_addr,
    output logic      busy_a,
    output logic      busy_b
);

    // Storage exists only for registers 1..REG_COUNT-1.
    reg_data_t                mem [1:REG_COUNT-1];
    logic [REG_COUNT-1:1]     busy;

    logic [REG_COUNT-1:1]     wr_sel;
    logic [REG_COUNT-1:1]     rsv_sel;

    // Full-width views with register 0 pinned to zero, so every address
    // value decodes to a defined word.
    reg_data_t                word_view [REG_COUNT];
    logic [REG_COUNT-1:0]     busy_view;

    logic                     hit_a;
    logic                     hit_b;

    regfile_wdec #(
        .ADDR_W    (ADDR_W),
        .REG_COUNT (REG_COUNT)
    ) u_wr_dec (
        .en   (wr_en),
        .addr (wr_addr),
        .sel  (wr_sel)
    );

    regfile_wdec #(
        .ADDR_W    (ADDR_W),
        .REG_COUNT (REG_COUNT)
    ) u_rsv_dec (
        .en   (rsv_en),
        .addr (rsv_addr),
        .sel  (rsv_sel)
    );

    // Register storage and scoreboard update at the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                mem[i]  <= '0;
                busy[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= wr_data;
                end
                // A reservation landing on the register being written means
                // a newer producer was issued, so it keeps the register busy.
                if (rsv_sel[i]) begin
                    busy[i] <= 1'b1;
                end else if (wr_sel[i]) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        word_view[0] = '0;
        busy_view[0] = 1'b0;
        for (int i = 1; i < REG_COUNT; i++) begin
            word_view[i] = mem[i];
            busy_view[i] = busy[i];
        end
    end

    // Same-cycle write hit on a read port; register 0 never bypasses.
    always_comb begin
        hit_a = wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != ZERO_REG);
        hit_b = wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != ZERO_REG);
    end

    always_comb begin
        if (rd_addr_a == ZERO_REG) begin
            rd_data_a = '0;
        end else if (hit_a) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = word_view[rd_addr_a];
        end

        if (rd_addr_b == ZERO_REG) begin
            rd_data_b = '0;
        end else if (hit_b) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = word_view[rd_addr_b];
        end
    end

    // A completing write clears busy for readers in the same cycle, matching
    // the data bypass. A same-cycle reservation is not visible until the
    // next cycle.
    always_comb begin
        busy_a = busy_view[rd_addr_a] && !hit_a;
        busy_b = busy_view[rd_addr_b] && !hit_b;
    end

endmodule : register_file_rw

// File: tb/tb_register_file_rw.sv
module tb_register_file_rw;
    import regfile_pkg::*;

    logic      clk;
    logic      reset;
    logic      wr_en;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    reg_addr_t rd_addr_a;
    reg_data_t rd_data_a;
    reg_addr_t rd_addr_b;
    reg_data_t rd_data_b;
    logic      rsv_en;
    reg_addr_t rsv_addr;
    logic      busy_a;
    logic      busy_b;

    int total;
    int bad;

    register_file_rw dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [4:0]  rsv_addr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_busy_b;
    } vec_t;

    localparam int NVEC = 18;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] rsa,
                         input logic [4:0] ra, input logic [4:0] rb);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rsv_en    = re;
        rsv_addr  = rsa;
        rd_addr_a = ra;
        rd_addr_b = rb;
    endtask

    initial begin
        // Each row is one cycle: inputs driven after the edge, outputs
        // checked at the falling edge, state commits at the next rising edge.
        //              we    wa     wd            re    rsa    ra     rb     exp_a         exp_b         ba    bb
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b0, 5'd0,  5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd7,  32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 5'd9,  32'h00000055, 1'b0, 5'd0,  5'd9,  5'd9,  32'h00000055, 32'h00000055, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h00000055, 32'h00000055, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 5'd3,  32'h00000077, 1'b1, 5'd3,  5'd3,  5'd3,  32'h00000077, 32'h00000077, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h00000077, 32'h00000077, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'h00000077, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 5'd3,  32'h00000088, 1'b1, 5'd10, 5'd3,  5'd10, 32'h00000088, 32'h0,        1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd10, 32'h00000088, 32'h0,        1'b0, 1'b1};
        tbl[15] = '{1'b1, 5'd4,  32'h00000099, 1'b1, 5'd4,  5'd4,  5'd4,  32'h00000099, 32'h00000099, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd4,  32'h00000099, 32'h00000099, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd5,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};

        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // After reset every register reads zero and is idle on both ports.
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            @(negedge clk);
            check($sformatf("rst_rd_a[%0d]", i), rd_data_a, 32'h0);
            check($sformatf("rst_rd_b[%0d]", 31 - i), rd_data_b, 32'h0);
            check($sformatf("rst_busy_a[%0d]", i), {31'b0, busy_a}, 32'h0);
            check($sformatf("rst_busy_b[%0d]", 31 - i), {31'b0, busy_b}, 32'h0);
            @(posedge clk);
            #1;
        end

        for (int v = 0; v < NVEC; v++) begin
            drive(tbl[v].wr_en, tbl[v].wr_addr, tbl[v].wr_data,
                  tbl[v].rsv_en, tbl[v].rsv_addr, tbl[v].ra, tbl[v].rb);
            @(negedge clk);
            check($sformatf("vec%0d_rd_a", v), rd_data_a, tbl[v].exp_a);
            check($sformatf("vec%0d_rd_b", v), rd_data_b, tbl[v].exp_b);
            check($sformatf("vec%0d_busy_a", v), {31'b0, busy_a}, {31'b0, tbl[v].exp_busy_a});
            check($sformatf("vec%0d_busy_b", v), {31'b0, busy_b}, {31'b0, tbl[v].exp_busy_b});
            @(posedge clk);
            #1;
        end

        // Reset while r4 (0x99) and r10 are busy; a write and reservation
        // presented during the reset cycle must be ignored.
        reset = 1'b1;
        drive(1'b1, 5'd6, 32'h00000BAD, 1'b1, 5'd6, 5'd4, 5'd6);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd6);
        @(negedge clk);
        check("post_rst_r4_data", rd_data_a, 32'h0);
        check("post_rst_r6_data", rd_data_b, 32'h0);
        check("post_rst_r4_busy", {31'b0, busy_a}, 32'h0);
        check("post_rst_r6_busy", {31'b0, busy_b}, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd9);
        @(negedge clk);
        check("post_rst_r10_busy", {31'b0, busy_a}, 32'h0);
        check("post_rst_r9_data", rd_data_b, 32'h0);
        @(posedge clk);
        #1;

        // The dropped producer's late write is accepted normally.
        drive(1'b1, 5'd4, 32'h00000011, 1'b0, 5'd0, 5'd4, 5'd0);
        @(negedge clk);
        check("late_wr_bypass", rd_data_a, 32'h00000011);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
        @(negedge clk);
        check("late_wr_rd_a", rd_data_a, 32'h00000011);
        check("late_wr_rd_b", rd_data_b, 32'h00000011);
        check("late_wr_busy", {31'b0, busy_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file_rw

// File: doc/register_file_rw.md
Name: register_file_rw

Overview:
- 32-entry x 32-bit architectural register file: one write port, two read ports, plus a per-register busy scoreboard.
- Sits between the write-back stage (upstream, drives the write port) and operand fetch (downstream, drives read addresses and checks busy).
- Word 0 is hardwired to zero.
- Reads see a same-cycle write (write-first bypass).

Parameters:
- DATA_W, 32, bits per register.
- REG_COUNT, 32, number of registers.
- ADDR_W, 5, register address width; log2(REG_COUNT).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write-back valid; commit wr_data to wr_addr at the next rising edge.
- wr_addr  input  ADDR_W  write destination.
- wr_data  input  DATA_W  write value.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_data_a  output  DATA_W  read port A data (combinational).
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_b  output  DATA_W  read port B data (combinational).
- rsv_en  input  1  issue reserves a destination; sets its busy bit.
- rsv_addr  input  ADDR_W  register being reserved.
- busy_a  output  1  register at rd_addr_a has a pending producer.
- busy_b  output  1  register at rd_addr_b has a pending producer.

Behaviour:
- Storage: REG_COUNT-1 clocked words (1..31); word 0 has no storage and always reads 0.
- Reset:
  - While reset=1 at a rising edge, all storage words clear to 0 and all busy bits clear to 0.
  - wr_en and rsv_en are ignored in that cycle.
  - Outputs after reset: rd_data_a/b = 0 for every address; busy_a/b = 0.
- Write:
  - wr_en=1 and wr_addr!=0 -> mem[wr_addr] <= wr_data at the edge.
  - wr_addr=0 -> no effect.
- Read (combinational, zero latency):
  - rd_data_x = 0 if rd_addr_x=0.
  - Otherwise, if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data (bypass).
  - Otherwise rd_data_x = mem[rd_addr_x].
  - Ports A and B are independent; both may address the same register.
- Scoreboard busy[1..31], clocked:
  - rsv_en=1 and rsv_addr!=0 -> busy[rsv_addr] <= 1.
  - wr_en=1 and wr_addr!=0 -> busy[wr_addr] <= 0.
  - Same address, both in one cycle -> busy stays/becomes 1 (reservation wins: a new producer was issued), while data is still written.
  - Different addresses -> both updates apply.
  - busy[0] is constant 0.
- busy_x output (combinational):
  - busy_x = busy[rd_addr_x] & ~(wr_en & wr_addr==rd_addr_x & wr_addr!=0).
  - A completing write in the current cycle makes its register non-busy to readers, consistent with the data bypass.
  - A same-cycle rsv_en does not affect busy_x until the next cycle.
- Writes to a non-busy register are legal and update data; busy is unchanged (remains 0).
- Reset mid-operation: any outstanding reservation is dropped; the pending producer's later write is still accepted as a normal write.
- No X propagation: every address value in 0..31 is decoded. There are no out-of-range addresses at REG_COUNT=32.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W, ADDR_W, REG_COUNT.
  - The reg_addr_t and reg_data_t typedefs.
  - The ZERO_REG constant (0).
- Sub-module regfile_wdec: ADDR_W-to-REG_COUNT one-hot decoder with enable, gating word 0 off.
  - The same instance type is reused twice: write enables (wr_en/wr_addr) and reservation sets (rsv_en/rsv_addr).
- Read muxes and bypass compare stay in the top module.

Test Plan:
- Reset then read all 32 addresses on both ports -> rd_data=0 and busy=0 everywhere.
- Write 0xDEADBEEF to r5; next cycle rd_addr_a=5 -> rd_data_a=0xDEADBEEF.
  - Write 0x12345678 to r0 -> rd_addr_b=0 reads 0.
- Bypass: wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with rd_addr_a=rd_addr_b=7 in the same cycle -> both ports show 0xA5A5A5A5 before the edge, and mem holds it after.
- Scoreboard:
  - rsv r9 -> next cycle busy_a=1 for rd_addr_a=9.
  - Write r9=0x55 -> busy_a=0 and rd_data_a=0x55 in that same cycle; busy stays 0 afterwards.
- Simultaneous rsv_addr=3 and wr_addr=3 (data 0x77) -> next cycle rd_data=0x77 and busy=1.
  - rsv r0 -> busy stays 0.
- Assert reset while r4 is busy and holds 0x99 -> next cycle r4 reads 0 with busy=0.
  - A subsequent write r4=0x11 reads back 0x11.
